// File: rtl/load_extend_unit.sv
// rtl/load_extend_unit.sv - load lane select, sign/zero extend, 2-entry output FIFO
//
// Purpose
//    Turns a raw memory read word into a register-file value for lw/lb/lbu/lh/lhu.
//    The byte or halfword lane is picked by the byte offset and then sign- or
//    zero-extended to DATA_WIDTH. Results, with their fault flags, are held in a
//    2-entry FIFO so the MEM/WB consumer can stall without losing beats.
//
// Ports (load_extend_unit)
//    Clk           in   rising-edge clock
//    Reset         in   synchronous, active-high reset
//    in_valid      in   input beat present
//    in_ready      out  unit can accept a beat (depends on fill level only)
//    in_data       in   raw memory read word
//    in_offset     in   byte offset, address[OFF_W-1:0]
//    in_mode       in   000 word, 001 byte s, 010 byte u, 011 half s, 100 half u
//    out_valid     out  head entry present
//    out_ready     in   consumer accepts head entry
//    out_data      out  extended result of head entry
//    out_misalign  out  half with offset[0]=1, or word with nonzero offset
//    out_badmode   out  mode 101..111; data passed through as a word

// Lane select and extension. Purely combinational; the result is registered
// by the FIFO, so nothing from in_* reaches out_* in the same cycle.
module load_extend_extract #(
   parameter int DATA_WIDTH = 32,
   parameter int OFF_W      = 2
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [OFF_W-1:0]      offset,
   input  logic [2:0]            mode,
   output logic [DATA_WIDTH-1:0] ext_data,
   output logic                  misalign,
   output logic                  badmode
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int NUM_HALVES = DATA_WIDTH / 16;

   localparam logic [2:0] MODE_WORD   = 3'b000;
   localparam logic [2:0] MODE_BYTE_S = 3'b001;
   localparam logic [2:0] MODE_BYTE_U = 3'b010;
   localparam logic [2:0] MODE_HALF_S = 3'b011;
   localparam logic [2:0] MODE_HALF_U = 3'b100;

   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;
   logic [OFF_W-1:0] half_idx;

   // The low offset bit is ignored for halfword selection; shifting it out
   // also keeps this legal when OFF_W is 1.
   assign half_idx = offset >> 1;

   always_comb begin
      byte_lane = 8'h00;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (offset == OFF_W'(i)) begin
            byte_lane = data[8*i +: 8];
         end
      end
   end

   always_comb begin
      half_lane = 16'h0000;
      for (int i = 0; i < NUM_HALVES; i++) begin
         if (half_idx == OFF_W'(i)) begin
            half_lane = data[16*i +: 16];
         end
      end
   end

   always_comb begin
      ext_data = data;
      misalign = 1'b0;
      badmode  = 1'b0;
      case (mode)
         MODE_WORD: begin
            ext_data = data;
            misalign = (offset != '0);
         end
         MODE_BYTE_S: ext_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
         MODE_BYTE_U: ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
         MODE_HALF_S: begin
            ext_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            misalign = offset[0];
         end
         MODE_HALF_U: begin
            ext_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            misalign = offset[0];
         end
         default: begin
            // Unknown encodings behave like a word load but never flag misalign.
            ext_data = data;
            badmode  = 1'b1;
         end
      endcase
   end

endmodule

// Two-entry FIFO: a head register that drives the outputs directly and a
// tail register that only fills while the head is stalled.
module load_extend_fifo #(
   parameter int WIDTH = 34
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   logic [1:0]       count;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             push;
   logic             pop;

   // Ready looks at the fill level only, so a stalled consumer never forms
   // a combinational loop back into the producer.
   assign wr_ready = (count != 2'd2);
   assign rd_valid = (count != 2'd0);
   assign rd_data  = head;
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head <= wr_data;
               end else begin
                  tail <= wr_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) begin
                  head <= tail;
               end
               count <= count - 2'd1;
            end
            2'b11: begin
               // Only reachable with one entry: the new beat replaces the
               // departing head and the level stays at one.
               head <= wr_data;
            end
            default: ;
         endcase
      end
   end

endmodule

module load_extend_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int OFF_W      = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [OFF_W-1:0]      in_offset,
   input  logic [2:0]            in_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_misalign,
   output logic                  out_badmode
);

   localparam int ENTRY_W = DATA_WIDTH + 2;

   logic [DATA_WIDTH-1:0] ext_data;
   logic                  ext_misalign;
   logic                  ext_badmode;
   logic [ENTRY_W-1:0]    head_entry;

   load_extend_extract #(
      .DATA_WIDTH(DATA_WIDTH),
      .OFF_W     (OFF_W)
   ) u_extract (
      .data    (in_data),
      .offset  (in_offset),
      .mode    (in_mode),
      .ext_data(ext_data),
      .misalign(ext_misalign),
      .badmode (ext_badmode)
   );

   // Flags travel with their beat so they always describe the head entry.
   load_extend_fifo #(
      .WIDTH(ENTRY_W)
   ) u_fifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .wr_valid(in_valid),
      .wr_ready(in_ready),
      .wr_data ({ext_badmode, ext_misalign, ext_data}),
      .rd_valid(out_valid),
      .rd_ready(out_ready),
      .rd_data (head_entry)
   );

   assign out_data     = head_entry[DATA_WIDTH-1:0];
   assign out_misalign = head_entry[DATA_WIDTH];
   assign out_badmode  = head_entry[DATA_WIDTH+1];

endmodule

// File: tb/tb_load_extend_unit.sv
// tb/tb_load_extend_unit.sv - scoreboard bench for load_extend_unit
module tb_load_extend_unit;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'h0;
   logic [1:0]  in_offset = 2'd0;
   logic [2:0]  in_mode = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_misalign;
   logic        out_badmode;

   load_extend_unit #(.DATA_WIDTH(32), .OFF_W(2)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_offset   (in_offset),
      .in_mode     (in_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_misalign(out_misalign),
      .out_badmode (out_badmode)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [31:0] d;
      logic        mis;
      logic        bad;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   bit   after_reset = 1'b0;

   // Reference: shift/mask arithmetic on the word, two's-complement by subtraction.
   function automatic exp_t model(input logic [31:0] data, input int off, input int mode);
      exp_t        e;
      int unsigned w;
      int unsigned b;
      int unsigned h;
      w = data;
      b = (w >> (8 * off)) % 256;
      h = (w >> (16 * (off / 2))) % 65536;
      e.d   = w;
      e.mis = 1'b0;
      e.bad = 1'b0;
      case (mode)
         0: e.mis = (off != 0);
         1: e.d = (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
         2: e.d = 32'(b);
         3: begin e.d = (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h); e.mis = (off % 2 == 1); end
         4: begin e.d = 32'(h); e.mis = (off % 2 == 1); end
         default: e.bad = 1'b1;
      endcase
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: compares at the falling edge, then advances the model with the
   // handshake that the next rising edge will perform.
   always @(negedge Clk) begin
      bit do_pop;
      bit do_push;
      if (after_reset) begin
         check("reset_out_data", out_data, 32'h0);
         check("reset_flags", {30'd0, out_misalign, out_badmode}, 32'h0);
         after_reset = 1'b0;
      end
      check("in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() > 0) begin
         check("out_data", out_data, q[0].d);
         check("out_misalign", {31'd0, out_misalign}, {31'd0, q[0].mis});
         check("out_badmode", {31'd0, out_badmode}, {31'd0, q[0].bad});
      end
      if (Reset) begin
         q.delete();
         after_reset = 1'b1;
      end else begin
         do_pop  = (q.size() != 0) && out_ready;
         do_push = in_valid && (q.size() != 2);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(model(in_data, int'(in_offset), int'(in_mode)));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Holds a beat until accepted, with a bounded wait.
   task automatic push_beat(input logic [31:0] d, input logic [1:0] off, input logic [2:0] mode);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1; in_data = d; in_offset = off; in_mode = mode;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge Clk);
         acc = in_ready;
         step();
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         $display("FAIL push_timeout: in_ready stayed 0, required 1");
      end
   endtask

   initial begin
      step(); step();
      Reset = 1'b0;
      step();

      // Byte lanes, signed and unsigned.
      out_ready = 1'b1;
      push_beat(32'h1234_80FF, 2'd0, 3'b001);
      push_beat(32'h1234_80FF, 2'd1, 3'b010);
      push_beat(32'h1234_80FF, 2'd1, 3'b001);
      // Half lanes, including misaligned unsigned half.
      push_beat(32'h8001_7FFE, 2'd2, 3'b011);
      push_beat(32'h8001_7FFE, 2'd3, 3'b100);
      push_beat(32'h8001_7FFE, 2'd1, 3'b011);
      push_beat(32'hCAFE_0001, 2'd2, 3'b000);
      step(); step();

      // Fill both entries with the consumer stalled, then drain.
      out_ready = 1'b0;
      push_beat(32'h11, 2'd0, 3'b000);
      push_beat(32'h22, 2'd0, 3'b000);
      step(); step();
      out_ready = 1'b1;
      step(); step(); step();

      // One entry held, then push and pop in the same cycle.
      out_ready = 1'b0;
      push_beat(32'hAAAA_0001, 2'd0, 3'b000);
      out_ready = 1'b1;
      push_beat(32'h0000_00C3, 2'd0, 3'b010);
      out_ready = 1'b0;
      step(); step();
      out_ready = 1'b1;
      step(); step();

      // Reset with a full FIFO and live handshakes on both sides.
      out_ready = 1'b0;
      push_beat(32'h33, 2'd0, 3'b000);
      push_beat(32'h44, 2'd0, 3'b000);
      Reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h55;
      step();
      Reset = 1'b0; in_valid = 1'b0;
      step();
      push_beat(32'hDEAD_BEEF, 2'd2, 3'b111);
      push_beat(32'hDEAD_BEEF, 2'd1, 3'b101);
      step(); step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         in_data   = $urandom;
         in_offset = 2'($urandom_range(0, 3));
         in_mode   = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 99) < 50);
         Reset     = ($urandom_range(0, 99) < 2);
         step();
      end
      Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation ran past 200000, required completion");
      $fatal(1);
   end

endmodule
